ps2_kbd_ctrl: RTL

Host-side PS/2 keyboard controller. It samples the keyboard's open-collector clock/data pair, deframes 11-bit device-to-host frames, and parses scan-code-set-2 prefixes (E0, F0). It tracks modifier state and queues decoded key events in a small FIFO with a valid/ready handshake. It sits between the board PS2_CLK1/PS2_DATA1 pins and any consumer logic; `Keyboard_behav` drives its pins in simulation.

---
 rtl/ps2_pkg.sv | 62 ++++++
 rtl/ps2_rx.sv | 128 ++++++++++++
 rtl/ps2_kbd_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard controller:
// receiver/decoder state encodings, scan-code prefixes, modifier keys
// and the event record stored in the FIFO.
package ps2_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    DEC_BASE,
    DEC_E0,
    DEC_F0,
    DEC_E0F0
  } dec_state_t;

  localparam logic [7:0] PFX_E0     = 8'hE0;
  localparam logic [7:0] PFX_F0     = 8'hF0;
  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CTRL   = 8'h14;
  localparam logic [7:0] KEY_ALT    = 8'h11;

  localparam int MOD_LSHIFT = 0;
  localparam int MOD_RSHIFT = 1;
  localparam int MOD_CTRL   = 2;
  localparam int MOD_LALT   = 3;
  localparam int MOD_RALT   = 4;
  localparam int MOD_W      = 5;

  typedef struct packed {
    logic [7:0]       code;
    logic             ext;
    logic             brk;
    logic [MOD_W-1:0] mods;
  } kbd_ev_t;

  // Modifier state after one decoded key: make sets the bit, break clears it.
  // E0 12 is the "fake shift" some keyboards emit, so lshift ignores it.
  function automatic logic [MOD_W-1:0] mods_apply(input logic [MOD_W-1:0] m,
                                                  input logic [7:0] code,
                                                  input logic ext,
                                                  input logic brk);
    logic [MOD_W-1:0] r;
    r = m;
    case (code)
      KEY_LSHIFT: if (!ext) r[MOD_LSHIFT] = ~brk;
      KEY_RSHIFT: r[MOD_RSHIFT] = ~brk;
      KEY_CTRL:   r[MOD_CTRL] = ~brk;
      KEY_ALT: begin
        if (ext) r[MOD_RALT] = ~brk;
        else     r[MOD_LALT] = ~brk;
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronizes and filters the raw
// clock/data pins, deframes 11-bit frames on clock falls and flags
// parity, framing and inter-edge timeout errors.
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 50_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_strobe,
  output logic [7:0] rx_byte,
  output logic       err_parity,
  output logic       err_frame
);
  import ps2_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic clk_p0, clk_p1, clk_p2, clk_p3, clk_f, clk_f_d;
  logic dat_p0, dat_p1, dat_p2, dat_p3, dat_f;
  logic fall, timeout;

  rx_state_t state, state_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    shreg;
  logic          par, par_nx;
  logic          shift_en;
  logic          strobe_nx, errp_nx, errf_nx;
  logic [TW-1:0] tmo_cnt;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Two-flop synchronizer, sample history and majority filter; idle bus is high.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      clk_p0 <= 1'b1; clk_p1 <= 1'b1; clk_p2 <= 1'b1; clk_p3 <= 1'b1;
      clk_f  <= 1'b1; clk_f_d <= 1'b1;
      dat_p0 <= 1'b1; dat_p1 <= 1'b1; dat_p2 <= 1'b1; dat_p3 <= 1'b1;
      dat_f  <= 1'b1;
    end else begin
      // sync stages
      clk_p0 <= ps2_clk;  clk_p1 <= clk_p0;
      dat_p0 <= ps2_data; dat_p1 <= dat_p0;
      // filter stages
      clk_p2 <= clk_p1;   clk_p3 <= clk_p2;
      dat_p2 <= dat_p1;   dat_p3 <= dat_p2;
      clk_f  <= maj3(clk_p1, clk_p2, clk_p3);
      dat_f  <= maj3(dat_p1, dat_p2, dat_p3);
      clk_f_d <= clk_f;
    end
  end

  assign fall = clk_f_d & ~clk_f;

  // Receiver next-state and one-cycle result flags.
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    par_nx     = par;
    shift_en   = 1'b0;
    strobe_nx  = 1'b0;
    errp_nx    = 1'b0;
    errf_nx    = 1'b0;
    timeout    = (state != RX_IDLE) && !fall && (tmo_cnt == TMO_LAST);
    if (timeout) begin
      state_nx = RX_IDLE;
      errf_nx  = 1'b1;
    end else if (fall) begin
      case (state)
        RX_IDLE: begin
          if (!dat_f) begin
            state_nx   = RX_SHIFT;
            bit_cnt_nx = 3'd0;
          end else begin
            errf_nx = 1'b1;
          end
        end
        RX_SHIFT: begin
          shift_en   = 1'b1;
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = RX_PARITY;
        end
        RX_PARITY: begin
          par_nx   = dat_f;
          state_nx = RX_STOP;
        end
        RX_STOP: begin
          state_nx = RX_IDLE;
          if (!dat_f)                errf_nx   = 1'b1;
          else if (!(^{shreg, par})) errp_nx   = 1'b1;
          else                       strobe_nx = 1'b1;
        end
        default: state_nx = RX_IDLE;
      endcase
    end
  end

  // Receiver state, shift register, timeout counter and registered flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= RX_IDLE;
      bit_cnt     <= 3'd0;
      par         <= 1'b0;
      shreg       <= 8'h00;
      tmo_cnt     <= '0;
      byte_strobe <= 1'b0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
    end else begin
      state       <= state_nx;
      bit_cnt     <= bit_cnt_nx;
      par         <= par_nx;
      if (shift_en) shreg <= {dat_f, shreg[7:1]};
      if (fall || state == RX_IDLE) tmo_cnt <= '0;
      else                          tmo_cnt <= tmo_cnt + 1'b1;
      byte_strobe <= strobe_nx;
      err_parity  <= errp_nx;
      err_frame   <= errf_nx;
    end
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// Host-side PS/2 keyboard controller: receives scan-code-set-2 bytes,
// folds E0/F0 prefixes into key events, tracks modifier keys and queues
// events in a show-ahead FIFO with a valid/ready handshake.
module ps2_kbd_ctrl #(
  parameter int TIMEOUT_CYCLES = 50_000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [4:0] ev_mods,
  output logic [4:0] mods,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow
);
  import ps2_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);

  logic       byte_strobe;
  logic [7:0] rx_byte;
  logic       rx_err;

  dec_state_t       dec_state, dec_nx;
  logic             emit;
  logic             ext_nx, brk_nx;
  logic [MOD_W-1:0] mods_nx;
  kbd_ev_t          ev_new;

  kbd_ev_t     mem [FIFO_DEPTH];
  kbd_ev_t     head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .CLK         (CLK),
    .RST         (RST),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .byte_strobe (byte_strobe),
    .rx_byte     (rx_byte),
    .err_parity  (err_parity),
    .err_frame   (err_frame)
  );

  assign rx_err = err_parity | err_frame;

  // Prefix decoder: E0 always restarts as extended, F0 marks a release
  // (keeping E0 only when it directly preceded), anything else is a key.
  always_comb begin
    dec_nx  = dec_state;
    emit    = 1'b0;
    ext_nx  = (dec_state == DEC_E0) || (dec_state == DEC_E0F0);
    brk_nx  = (dec_state == DEC_F0) || (dec_state == DEC_E0F0);
    mods_nx = mods;
    if (rx_err) begin
      dec_nx = DEC_BASE;
    end else if (byte_strobe) begin
      if (rx_byte == PFX_E0) begin
        dec_nx = DEC_E0;
      end else if (rx_byte == PFX_F0) begin
        dec_nx = (dec_state == DEC_E0) ? DEC_E0F0 : DEC_F0;
      end else begin
        emit    = 1'b1;
        dec_nx  = DEC_BASE;
        mods_nx = mods_apply(mods, rx_byte, ext_nx, brk_nx);
      end
    end
    ev_new = '{code: rx_byte, ext: ext_nx, brk: brk_nx, mods: mods_nx};
  end

  // Decoder state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) dec_state <= DEC_BASE;
    else      dec_state <= dec_nx;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ev_valid & ev_ready;
  assign push  = emit & (~full | pop);

  // FIFO pointers, live modifier state and the overflow pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mods     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      mods     <= mods_nx;
      overflow <= emit & full & ~pop;
    end
  end

  // FIFO storage; a write into the slot being popped is safe since the
  // head is read combinationally before the edge.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= ev_new;
  end

  // Show-ahead head, forced to zero while empty so outputs are clean at reset.
  always_comb begin
    head     = mem[rd_ptr[AW-1:0]];
    ev_valid = ~empty;
    ev_code  = 8'h00;
    ev_ext   = 1'b0;
    ev_break = 1'b0;
    ev_mods  = '0;
    if (!empty) begin
      ev_code  = head.code;
      ev_ext   = head.ext;
      ev_break = head.brk;
      ev_mods  = head.mods;
    end
  end

endmodule
